// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle MULT / MULTU / DIV / DIVU engine with architectural HI/LO
// registers. It sits beside the ALU and takes the register-file read data as
// operands. While an operation runs, busy stays high so the control unit
// holds the PC. done pulses for one cycle when hi/lo carry the new result.
//
// Operation codes (op):
//   2'b00 MULT   signed multiply      {hi,lo} = a * b
//   2'b01 MULTU  unsigned multiply    {hi,lo} = a * b
//   2'b10 DIV    signed divide        lo = a / b, hi = a % b
//   2'b11 DIVU   unsigned divide      lo = a / b, hi = a % b
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset, aborts any operation
//   start        in   launch op with a/b (only sampled while idle)
//   op           in   operation select, see table above
//   a            in   rs operand (multiplicand / dividend)
//   b            in   rt operand (multiplier / divisor)
//   hi_we        in   MTHI: hi <= wdata (only while idle)
//   lo_we        in   MTLO: lo <= wdata (only while idle)
//   wdata        in   MTHI/MTLO data
//   busy         out  an operation is in flight
//   done         out  one-cycle pulse, hi/lo hold the new result
//   div_by_zero  out  last DIV/DIVU had a zero divisor (cleared by next start)
//   hi           out  HI register (upper product / remainder)
//   lo           out  LO register (lower product / quotient)
//
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, MULT/MULTU use a single-cycle multiplier
//                       and skip the iterative phase (done one edge after the
//                       start edge). Division is always iterative.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      counter;
    logic [1:0]         op_q;

    // Datapath state: acc is the shared 2*WIDTH working register.
    //   multiply: {partial product high, multiplier shifting out low}
    //   divide:   {partial remainder, dividend shifting out / quotient in}
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;       // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   a_raw;      // original dividend for the divide-by-zero result
    logic               neg_main;   // negate product / quotient
    logic               neg_rem;    // negate remainder (dividend was negative)
    logic               b_zero;

    // Conditional two's-complement negation used by the sign fix-up.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                        input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Operand conditioning: signed ops work on magnitudes, unsigned ops on raw values.
    logic             is_signed_in;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        is_signed_in = ~op[0];
        sign_a       = is_signed_in & a[WIDTH-1];
        sign_b       = is_signed_in & b[WIDTH-1];
        mag_a        = cond_neg_w(a, sign_a);
        mag_b        = cond_neg_w(b, sign_b);
    end

    // One iteration of each algorithm.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_mul_next;
    logic [2*WIDTH-1:0] acc_div_next;

    always_comb begin
        // Shift-add: add the multiplicand to the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring division: shift in the next dividend bit, try to subtract
        // the divisor; the borrow bit decides whether the trial is kept.
        div_trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        if (div_trial[WIDTH])
            acc_div_next = {acc[2*WIDTH-2:0], 1'b0};
        else
            acc_div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // Final sign correction and result selection.
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod_fixed = cond_neg_2w(acc, neg_main);
        if (!op_q[1]) begin
            res_hi = prod_fixed[2*WIDTH-1:WIDTH];
            res_lo = prod_fixed[WIDTH-1:0];
        end else if (b_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            // Most-negative / -1 falls out naturally: the magnitude quotient
            // 2^(WIDTH-1) is not negated and reads back as the same pattern.
            res_hi = cond_neg_w(acc[2*WIDTH-1:WIDTH], neg_rem);
            res_lo = cond_neg_w(acc[WIDTH-1:0], neg_main);
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_next = op[1] ? S_CALC : S_FIXUP;
`else
                    state_next = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (counter == LAST_ITER)
                    state_next = S_FIXUP;
            end
            S_FIXUP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Control and architectural registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            counter     <= '0;
            op_q        <= 2'b00;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A same-cycle start still lets MTHI/MTLO land; the
                    // result overwrites them at the end of the operation.
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        op_q        <= op;
                        counter     <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                S_CALC: begin
                    counter <= counter + CW'(1);
                end
                S_FIXUP: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    done        <= 1'b1;
                    div_by_zero <= op_q[1] & b_zero;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers (no reset: contents only matter inside an operation)
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            opnd     <= op[1] ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            a_raw    <= a;
            neg_main <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            b_zero   <= (b == '0);
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1])
                acc <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
        end else if (state == S_CALC) begin
            acc <= op_q[1] ? acc_div_next : acc_mul_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit (WIDTH = 32). Directed cases for the
// documented corner results plus randomized operations, all compared against
// a plain-arithmetic reference model. Also exercises MTHI/MTLO, ignored
// start/write while busy, and asynchronous abort.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model of hi/lo
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: MIPS semantics in plain integer arithmetic.
    task automatic ref_model(input logic [1:0] rop, input logic [W-1:0] ra, input logic [W-1:0] rb,
                             output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
        longint          sa, sb, q, r;
        logic [63:0]     p;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        rz = 1'b0;
        case (rop)
            2'b00: begin
                p  = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, ra} * {32'b0, rb};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (rb == 0) begin
                    rz = 1'b1;
                    rh = ra;
                    rl = 32'hFFFF_FFFF;
                end else if (rop == 2'b10) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    rl = q[31:0];
                    rh = r[31:0];
                end else begin
                    rl = ra / rb;
                    rh = ra % rb;
                end
            end
        endcase
    endtask

    // Launch one operation, measure latency, and check everything at done.
    task automatic run_op(input logic [1:0] rop, input logic [W-1:0] ra, input logic [W-1:0] rb);
        logic [W-1:0] eh, el;
        logic         ez;
        int           n, exp_lat;
        logic         busy_ok;
        ref_model(rop, ra, rb, eh, el, ez);
        exp_lat = (FAST && !rop[1]) ? 1 : W + 1;
        @(negedge clk);
        start = 1'b1; op = rop; a = ra; b = rb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom;   // operands must be latched, not re-read
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("latency op%0d", rop), 64'(n), 64'(exp_lat));
        chk("busy_during_op", {63'b0, busy_ok}, 64'd1);
        chk("busy_at_done", {63'b0, busy}, 64'd0);
        chk($sformatf("hi op%0d a=%0h b=%0h", rop, ra, rb), {32'b0, hi}, {32'b0, eh});
        chk($sformatf("lo op%0d a=%0h b=%0h", rop, ra, rb), {32'b0, lo}, {32'b0, el});
        chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, ez});
        m_hi = eh;
        m_lo = el;
        @(posedge clk);
        #1;
        chk("done_pulse_width", {63'b0, done}, 64'd0);
        chk("hi_hold", {32'b0, hi}, {32'b0, m_hi});
    endtask

    task automatic mt_write(input logic hw, input logic lw, input logic [W-1:0] d);
        @(negedge clk);
        hi_we = hw; lo_we = lw; wdata = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        chk("mt_hi", {32'b0, hi}, {32'b0, m_hi});
        chk("mt_lo", {32'b0, lo}, {32'b0, m_lo});
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h0000_0007;
        if ($urandom_range(0, 2) == 0)
            return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner results
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t1_hi", {32'b0, hi}, 64'hFFFF_FFFE);
        chk("t1_lo", {32'b0, lo}, 64'h0000_0001);
        run_op(2'b00, -32'sd3, 32'd7);
        chk("t2_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        chk("t2_lo", {32'b0, lo}, 64'hFFFF_FFEB);
        run_op(2'b10, -32'sd7, 32'd2);
        chk("t3_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        chk("t3_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        run_op(2'b11, 32'd100, 32'd7);
        chk("t3u_lo", {32'b0, lo}, 64'd14);
        chk("t3u_hi", {32'b0, hi}, 64'd2);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("t4_lo", {32'b0, lo}, 64'h8000_0000);
        chk("t4_hi", {32'b0, hi}, 64'd0);
        run_op(2'b11, 32'd5, 32'd0);
        chk("t4z_lo", {32'b0, lo}, 64'hFFFF_FFFF);
        chk("t4z_hi", {32'b0, hi}, 64'd5);
        chk("t4z_dbz", {63'b0, div_by_zero}, 64'd1);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0);      // signed divide by zero: hi = raw a
        run_op(2'b01, 32'd6, 32'd7);              // also clears div_by_zero
        chk("t6_lo", {32'b0, lo}, 64'd42);

        // MTHI / MTLO
        mt_write(1'b1, 1'b0, 32'hCAFE_0001);
        mt_write(1'b0, 1'b1, 32'hBEEF_0002);
        mt_write(1'b1, 1'b1, 32'h1234_5678);

        // Start and MTHI while busy are ignored; async reset aborts.
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b00; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0;
        chk("busy_ignore_busy", {63'b0, busy}, 64'd1);
        chk("busy_ignore_hi", {32'b0, hi}, {32'b0, m_hi});
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hi", {32'b0, hi}, 64'd0);
        chk("abort_lo", {32'b0, lo}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b11, 32'd1000, 32'd3);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
